spike_window_decoder: RTL and testbench
=======================================

# spike_window_decoder

Downstream readout stage for the LIF neuron network. Counts spikes from the three input neurons and the output neuron over a fixed window of clock cycles. At the end of each window it presents the per-neuron counts and a winner index through a valid/ready handshake. It turns the network's raw single-cycle spike pulses into stable, host-readable rate results.

## Interface
- WINDOW, 16, number of sampled cycles per window; legal range 2..255
- CNT_W, 5, width of each spike counter; counters saturate at 2^CNT_W-1
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain only
- enable  input  1  start/continue windowed counting
- spike_1  input  1  spike pulse from input neuron 1
- spike_2  input  1  spike pulse from input neuron 2
- spike_3  input  1  spike pulse from input neuron 3
- spike_output  input  1  spike pulse from the output neuron
- result_ready  input  1  consumer accepts the result
- result_valid  output  1  result registers hold a completed window
- count_1  output  CNT_W  spikes counted on spike_1 in the last window
- count_2  output  CNT_W  spikes counted on spike_2 in the last window
- count_3  output  CNT_W  spikes counted on spike_3 in the last window
- count_out  output  CNT_W  spikes counted on spike_output in the last window
- winner  output  2  index 1..3 of the input neuron with the highest count; 0 if all three counts are zero
- saturated  output  1  at least one counter hit its maximum during the last window
- result_missed  output  1  spikes arrived while the previous result was waiting in REPORT, so they were not counted
- busy  output  1  state is COUNT

## Operation
- FSM states: IDLE, COUNT, REPORT. Reset puts the FSM in IDLE.
- IDLE:
  - Internal accumulators and the window counter are held at 0.
  - If enable=1 at a clock edge, go to COUNT.
- COUNT:
  - Each cycle, every accumulator whose spike input is 1 increments by 1. At 2^CNT_W-1 it holds, and the window's saturation flag is set.
  - The window counter runs 0..WINDOW-1.
  - On the edge where the window counter equals WINDOW-1:
    - That cycle's spikes are included in the counts.
    - Final counts, winner, saturated and result_missed are registered to the outputs.
    - The FSM goes to REPORT.
  - Deasserting enable during COUNT does not abort the window.
- Winner rule:
  - Compare the three input-neuron counts, after saturation.
  - Strictly greatest wins.
  - Ties go to the lowest index.
  - If all three are zero, winner=0.
  - count_out does not take part.
- REPORT:
  - result_valid=1 and all result outputs are held stable.
  - A transfer occurs on an edge where result_valid=1 and result_ready=1.
  - On transfer: if enable=1, go to COUNT with accumulators, window counter and saturation flag cleared. If enable=0, go to IDLE.
  - Spikes during any REPORT cycle, including the transfer cycle, are not counted. They set the miss_pending flag.
- result_missed and miss_pending:
  - result_missed reports miss_pending as it stands at the end of the next window.
  - miss_pending clears on that same edge.
- Output values between events:
  - Result outputs keep their last values in IDLE and COUNT.
  - result_valid is 0 outside REPORT.

## Timing
- Reset values, asserted asynchronously:
  - result_valid=0, busy=0, saturated=0, result_missed=0.
  - count_1, count_2, count_3 and count_out = 0; winner=0.
  - FSM=IDLE, miss_pending=0.
- Start of counting: enable is sampled high at edge E0. busy=1 from E0. The first sampled cycle is the cycle following E0.
- Window length: exactly WINDOW sampled cycles.
- Result latency: result_valid rises at the edge that samples the WINDOW-th cycle and is visible in the next cycle.
- Back-to-back throughput: with result_ready and enable held high, REPORT lasts 1 cycle, so the window period is WINDOW+1 cycles.
- Backpressure: with result_ready low, REPORT holds indefinitely and outputs do not change.
- Reset mid-window or mid-REPORT: all state returns immediately to reset values. Partial counts are discarded and no result is produced.
- Width arithmetic: all counters are unsigned CNT_W bits with no wrap-around. The window counter is 8 bits.

## Test plan
- Reset, then enable=1, spike_1 high every 2nd cycle, spike_2 every 4th, spike_3 never, WINDOW=16, ready=1 -> result_valid 17 cycles after enable edge; count_1=8, count_2=4, count_3=0, winner=1, saturated=0.
- Tie: spike_2 and spike_3 both high every cycle of a window -> count_2=count_3=16, winner=2; a window with no spikes -> winner=0.
- Saturation: WINDOW=40, CNT_W=5, spike_output held high -> count_out=31, saturated=1, other counts 0.
- Backpressure: hold result_ready=0 for 10 cycles after result_valid while spike_1 pulses -> outputs stable, result_valid stays 1; after ready, next window's result has result_missed=1 and following window result_missed=0.
- Continuous mode: enable and ready held high for 3 windows -> result_valid pulses exactly every 17 cycles; drop enable mid-window -> window completes, then IDLE after transfer.
- Assert reset mid-COUNT at cycle 7 -> all outputs 0 immediately; re-enable -> fresh 16-cycle window with counts starting from 0.

Source files
------------

// File: rtl/spike_window_decoder.sv
// Windowed spike-rate readout: counts spikes per neuron over WINDOW cycles and
// presents counts plus a winner index through a valid/ready handshake.
module spike_window_decoder #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_1,
  input  logic             spike_2,
  input  logic             spike_3,
  input  logic             spike_output,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] count_1,
  output logic [CNT_W-1:0] count_2,
  output logic [CNT_W-1:0] count_3,
  output logic [CNT_W-1:0] count_out,
  output logic [1:0]       winner,
  output logic             saturated,
  output logic             result_missed,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [7:0]       WinLast = 8'(WINDOW - 1);

  typedef enum logic [1:0] {StIdle, StCount, StReport} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              win_q, win_d;
  logic [3:0][CNT_W-1:0]   acc_q, acc_d, acc_inc;
  logic                    sat_q, sat_d, sat_inc;
  logic                    miss_q, miss_d;
  logic                    load;
  logic [1:0]              win_idx;
  logic [3:0]              spk;

  assign spk = {spike_output, spike_3, spike_2, spike_1};

  // Accumulators after this cycle's spikes, saturating at CntMax.
  always_comb begin
    sat_inc = sat_q;
    for (int i = 0; i < 4; i++) begin
      acc_inc[i] = (spk[i] && (acc_q[i] != CntMax)) ? acc_q[i] + CntOne : acc_q[i];
      if (acc_inc[i] == CntMax) sat_inc = 1'b1;
    end
  end

  // Strictly greatest input count wins; ties resolve to the lowest index.
  always_comb begin
    win_idx = 2'd0;
    if (acc_inc[0] != '0 && acc_inc[0] >= acc_inc[1] && acc_inc[0] >= acc_inc[2]) begin
      win_idx = 2'd1;
    end else if (acc_inc[1] != '0 && acc_inc[1] >= acc_inc[2]) begin
      win_idx = 2'd2;
    end else if (acc_inc[2] != '0) begin
      win_idx = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    miss_d  = miss_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        win_d = '0;
        sat_d = 1'b0;
        if (enable) state_d = StCount;
      end
      StCount: begin
        acc_d = acc_inc;
        sat_d = sat_inc;
        win_d = win_q + 8'd1;
        if (win_q == WinLast) begin
          load    = 1'b1;
          state_d = StReport;
          acc_d   = '0;
          win_d   = '0;
          sat_d   = 1'b0;
          miss_d  = 1'b0;
        end
      end
      StReport: begin
        // Spikes here are dropped; flag them for the next window's result.
        if (|spk) miss_d = 1'b1;
        if (result_ready) state_d = enable ? StCount : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      win_q         <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      miss_q        <= 1'b0;
      count_1       <= '0;
      count_2       <= '0;
      count_3       <= '0;
      count_out     <= '0;
      winner        <= '0;
      saturated     <= 1'b0;
      result_missed <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      miss_q  <= miss_d;
      if (load) begin
        count_1       <= acc_inc[0];
        count_2       <= acc_inc[1];
        count_3       <= acc_inc[2];
        count_out     <= acc_inc[3];
        winner        <= win_idx;
        saturated     <= sat_inc;
        result_missed <= miss_q;
      end
    end
  end

  assign result_valid = (state_q == StReport);
  assign busy         = (state_q == StCount);

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench: expected window results are queued as spikes are driven and
// compared when the decoder presents each result.
module tb_spike_window_decoder;

  typedef struct {
    logic [4:0] c1, c2, c3, co;
    logic [1:0] win;
    logic       sat, miss;
  } res_t;

  logic clk, reset, enable, spike_1, spike_2, spike_3, spike_output, result_ready;
  logic result_valid, saturated, result_missed, busy;
  logic [4:0] count_1, count_2, count_3, count_out;
  logic [1:0] winner;

  logic s_enable, s_spike_out, s_ready, s_zero;
  logic s_valid, s_sat, s_missed, s_busy;
  logic [4:0] s_c1, s_c2, s_c3, s_co;
  logic [1:0] s_win;

  res_t sb[$];
  res_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  spike_window_decoder #(.WINDOW(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_1(spike_1), .spike_2(spike_2),
    .spike_3(spike_3), .spike_output(spike_output), .result_ready(result_ready),
    .result_valid(result_valid), .count_1(count_1), .count_2(count_2), .count_3(count_3),
    .count_out(count_out), .winner(winner), .saturated(saturated),
    .result_missed(result_missed), .busy(busy)
  );

  spike_window_decoder #(.WINDOW(40), .CNT_W(5)) dut_sat (
    .clk(clk), .reset(reset), .enable(s_enable), .spike_1(s_zero), .spike_2(s_zero),
    .spike_3(s_zero), .spike_output(s_spike_out), .result_ready(s_ready),
    .result_valid(s_valid), .count_1(s_c1), .count_2(s_c2), .count_3(s_c3),
    .count_out(s_co), .winner(s_win), .saturated(s_sat), .result_missed(s_missed),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic pulse(input int k, input int p);
    if (p == 0) return 1'b0;
    return (k % p) == 0;
  endfunction

  function automatic logic [4:0] bump(input logic [4:0] c, input logic s);
    return (s && c != 5'd31) ? c + 5'd1 : c;
  endfunction

  function automatic logic [1:0] model_winner(input res_t e);
    logic [4:0] c[3];
    logic [4:0] best_v;
    logic [1:0] best;
    c[0] = e.c1; c[1] = e.c2; c[2] = e.c3;
    best_v = 5'd0;
    best   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (c[i] > best_v) begin
        best_v = c[i];
        best   = 2'(i + 1);
      end
    end
    return best;
  endfunction

  task automatic check_result(input string tag, input logic [4:0] o1, input logic [4:0] o2,
                              input logic [4:0] o3, input logic [4:0] oo,
                              input logic [1:0] ow, input logic os, input logic om);
    res_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed=result expected=none queued", tag);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check({tag, "_count_1"}, 8'(o1), 8'(e.c1));
      check({tag, "_count_2"}, 8'(o2), 8'(e.c2));
      check({tag, "_count_3"}, 8'(o3), 8'(e.c3));
      check({tag, "_count_out"}, 8'(oo), 8'(e.co));
      check({tag, "_winner"}, 8'(ow), 8'(e.win));
      check({tag, "_saturated"}, 8'(os), 8'(e.sat));
      check({tag, "_missed"}, 8'(om), 8'(e.miss));
    end
  endtask

  // Starts one cycle after the edge that entered COUNT; ends #1 after the result edge.
  task automatic run_window(input string tag, input int p1, input int p2, input int p3,
                            input int po, input logic miss, input int drop_at);
    res_t e;
    e = '{c1: 5'd0, c2: 5'd0, c3: 5'd0, co: 5'd0, win: 2'd0, sat: 1'b0, miss: 1'b0};
    for (int k = 0; k < 16; k++) begin
      if (k == drop_at) enable = 1'b0;
      spike_1      = pulse(k, p1);
      spike_2      = pulse(k, p2);
      spike_3      = pulse(k, p3);
      spike_output = pulse(k, po);
      e.c1 = bump(e.c1, spike_1);
      e.c2 = bump(e.c2, spike_2);
      e.c3 = bump(e.c3, spike_3);
      e.co = bump(e.co, spike_output);
      if (e.c1 == 5'd31 || e.c2 == 5'd31 || e.c3 == 5'd31 || e.co == 5'd31) e.sat = 1'b1;
      @(posedge clk);
      #1;
      if (k == 14) check({tag, "_valid_early"}, 8'(result_valid), 8'd0);
    end
    {spike_1, spike_2, spike_3, spike_output} = 4'b0;
    e.win  = model_winner(e);
    e.miss = miss;
    sb.push_back(e);
    check({tag, "_valid_rise"}, 8'(result_valid), 8'd1);
    check({tag, "_busy_report"}, 8'(busy), 8'd0);
    check_result(tag, count_1, count_2, count_3, count_out, winner, saturated, result_missed);
  endtask

  task automatic transfer(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_fall"}, 8'(result_valid), 8'd0);
    check({tag, "_busy_after"}, 8'(busy), 8'(enable));
  endtask

  initial begin
    res_t e;
    reset = 1'b0;
    enable = 1'b0;
    result_ready = 1'b0;
    {spike_1, spike_2, spike_3, spike_output} = 4'b0;
    s_enable = 1'b0;
    s_spike_out = 1'b0;
    s_ready = 1'b1;
    s_zero = 1'b0;
    #3;
    check("rst_valid", 8'(result_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_counts", 8'({count_1, count_2, count_3, count_out} == 20'd0), 8'd1);
    check("rst_winner", 8'(winner), 8'd0);
    check("rst_flags", 8'({saturated, result_missed}), 8'd0);

    // Three back-to-back windows, 17-cycle period with enable and ready high.
    @(posedge clk);
    #1;
    reset = 1'b1;
    enable = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("start_busy", 8'(busy), 8'd1);
    run_window("rate", 2, 4, 0, 0, 1'b0, -1);
    transfer("rate");
    run_window("tie", 0, 1, 1, 0, 1'b0, -1);
    transfer("tie");
    run_window("quiet", 0, 0, 0, 0, 1'b0, -1);

    // Backpressure while spike_1 pulses: result held, spikes flagged as missed.
    result_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      spike_1 = (i % 2) == 0;
      @(posedge clk);
      #1;
      check("bp_valid", 8'(result_valid), 8'd1);
      check("bp_count_1", 8'(count_1), 8'(last_exp.c1));
      check("bp_winner", 8'(winner), 8'(last_exp.win));
    end
    spike_1 = 1'b0;
    transfer("bp");
    run_window("missed", 1, 0, 0, 0, 1'b1, -1);
    transfer("missed");
    run_window("after_miss", 3, 0, 0, 1, 1'b0, -1);
    transfer("after_miss");

    // Enable dropped mid-window: window completes, then IDLE after transfer.
    run_window("drop", 0, 0, 2, 0, 1'b0, 8);
    transfer("drop");
    @(posedge clk);
    #1;
    check("idle_busy", 8'(busy), 8'd0);
    check("idle_valid", 8'(result_valid), 8'd0);
    check("idle_hold_count_3", 8'(count_3), 8'd8);

    // Reset in the middle of a window.
    enable = 1'b1;
    @(posedge clk);
    #1;
    spike_1 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_valid", 8'(result_valid), 8'd0);
    check("mid_rst_count_3", 8'(count_3), 8'd0);
    check("mid_rst_winner", 8'(winner), 8'd0);
    reset = 1'b1;
    spike_1 = 1'b0;
    @(posedge clk);
    #1;
    check("restart_busy", 8'(busy), 8'd1);
    run_window("fresh", 1, 0, 0, 0, 1'b0, -1);
    enable = 1'b0;
    transfer("fresh");

    // Saturation on the 40-cycle instance.
    s_enable = 1'b1;
    @(posedge clk);
    #1;
    s_enable = 1'b0;
    e = '{c1: 5'd0, c2: 5'd0, c3: 5'd0, co: 5'd0, win: 2'd0, sat: 1'b0, miss: 1'b0};
    s_spike_out = 1'b1;
    for (int k = 0; k < 40; k++) begin
      e.co = bump(e.co, 1'b1);
      if (e.co == 5'd31) e.sat = 1'b1;
      @(posedge clk);
      #1;
      if (k == 38) check("sat_valid_early", 8'(s_valid), 8'd0);
    end
    s_spike_out = 1'b0;
    e.win = model_winner(e);
    sb.push_back(e);
    check("sat_valid_rise", 8'(s_valid), 8'd1);
    check_result("sat", s_c1, s_c2, s_c3, s_co, s_win, s_sat, s_missed);
    @(posedge clk);
    #1;
    check("sat_idle_busy", 8'(s_busy), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
